// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Width constants and the loader state encoding. The FIR filter uses the same
// width constants, so the loader and the filter agree on the coefficient-write
// port shape.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package fir_pkg;

  localparam int FIR_COEF_W = 8;   // coefficient width
  localparam int FIR_DATA_W = 8;   // sample width
  localparam int FIR_IDX_W  = 4;   // coef_number width
  localparam int FIR_N_TAPS = 5;   // default coefficients per load

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_coef_loader_if.sv
// -----------------------------------------------------------------------------
// fir_coef_loader_if
// Coefficient byte stream (valid/ready) from the host into the loader.
//   s_coef_valid : host has a coefficient byte
//   s_coef_ready : loader accepts the byte this cycle
//   s_coef_data  : coefficient byte, tap order 0..N_TAPS-1
// Modports: master = host side, slave = loader side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface fir_coef_loader_if
  import fir_pkg::*;
#(
  parameter int COEF_W = FIR_COEF_W
);

  logic              s_coef_valid;
  logic              s_coef_ready;
  logic [COEF_W-1:0] s_coef_data;

  modport master (
    output s_coef_valid,
    output s_coef_data,
    input  s_coef_ready
  );

  modport slave (
    input  s_coef_valid,
    input  s_coef_data,
    output s_coef_ready
  );

endinterface

// File: rtl/fir_tap_counter.sv
// -----------------------------------------------------------------------------
// fir_tap_counter
// Synchronous-clear, enabled counter that wraps to zero after its terminal
// value N_TAPS-1, so it never exceeds N_TAPS-1.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   clr   : synchronous clear (priority over en)
//   en    : count enable
//   count : current value
//   tc    : count is at N_TAPS-1
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fir_tap_counter
  import fir_pkg::*;
#(
  parameter int IDX_W  = FIR_IDX_W,
  parameter int N_TAPS = FIR_N_TAPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] count,
  output logic             tc
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_TAPS - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + IDX_W'(1);
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// -----------------------------------------------------------------------------
// fir_coef_loader
// Takes N_TAPS coefficient bytes from the host stream and writes them into the
// FIR filter as indexed single-cycle writes, then feeds the filter N_TAPS zero
// samples to flush its delay line and pulses done. While loading/flushing the
// upstream sample stream is gated off the filter input.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : request a reload (honoured in IDLE only, beats abort)
//   abort             : cancel a load/flush (ignored in IDLE/DONE)
//   s_coef            : coefficient byte stream (slave modport)
//   sample_in         : upstream samples
//   sample_out        : to filter input_data (registered passthrough or zero)
//   coef_write_enable : to filter, one cycle per accepted byte
//   coef_number       : to filter, tap index of the write
//   coef_value        : to filter, coefficient of the write
//   busy              : high while loading or flushing
//   done              : one-cycle pulse after a complete load + flush
//   checksum          : (FIR_COEF_LOADER_CHECKSUM_EN only) mod-2^COEF_W sum of
//                       the bytes accepted in the current load
//
// Optional feature macro: FIR_COEF_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int N_TAPS = FIR_N_TAPS,
  parameter int COEF_W = FIR_COEF_W,
  parameter int IDX_W  = FIR_IDX_W,
  parameter int DATA_W = FIR_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  fir_coef_loader_if.slave   s_coef,
  input  logic [DATA_W-1:0]  sample_in,
  output logic [DATA_W-1:0]  sample_out,
  output logic               coef_write_enable,
  output logic [IDX_W-1:0]   coef_number,
  output logic [COEF_W-1:0]  coef_value,
  output logic               busy,
  output logic               done
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
  ,
  output logic [COEF_W-1:0]  checksum
`endif
);

  fir_state_e        state;
  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic              idx_tc;
  logic [IDX_W-1:0]  flush_cnt_unused;
  logic              flush_tc;

  logic              wr_vld_p1;
  logic [IDX_W-1:0]  wr_num_p1;
  logic [COEF_W-1:0] wr_val_p1;
  logic [DATA_W-1:0] smp_p1;

  assign s_coef.s_coef_ready = (state == ST_LOAD);
  assign accept              = s_coef.s_coef_valid & s_coef.s_coef_ready;

  // Tap index: held at zero outside LOAD so every load starts at tap 0.
  fir_tap_counter #(
    .IDX_W  (IDX_W),
    .N_TAPS (N_TAPS)
  ) u_idx_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_LOAD),
    .en    (accept),
    .count (idx),
    .tc    (idx_tc)
  );

  // Flush length: counts FLUSH cycles from entry; tc marks the N_TAPS-th one.
  fir_tap_counter #(
    .IDX_W  (IDX_W),
    .N_TAPS (N_TAPS)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_FLUSH),
    .en    (state == ST_FLUSH),
    .count (flush_cnt_unused),
    .tc    (flush_tc)
  );

  // Stage p0 -> p1: accepted byte becomes a filter write one cycle later,
  // FSM advances and the filter sample input is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_vld_p1 <= 1'b0;
      wr_num_p1 <= '0;
      wr_val_p1 <= '0;
      smp_p1    <= '0;
    end else begin
      // A write from an accept in the abort cycle still goes out.
      wr_vld_p1 <= accept;
      if (accept) begin
        wr_num_p1 <= idx;
        wr_val_p1 <= s_coef.s_coef_data;
      end

      done <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          smp_p1 <= sample_in;
          if (start) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          smp_p1 <= '0;
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (accept && idx_tc) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          smp_p1 <= '0;
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (flush_tc) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          smp_p1 <= sample_in;
          state  <= ST_IDLE;
        end
        default: begin
          smp_p1 <= '0;
          state  <= ST_IDLE;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  assign coef_write_enable = wr_vld_p1;
  assign coef_number       = wr_num_p1;
  assign coef_value        = wr_val_p1;
  assign sample_out        = smp_p1;

`ifdef FIR_COEF_LOADER_CHECKSUM_EN
  logic [COEF_W-1:0] csum_p1;

  // Running sum restarts when a load is started and is held after done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_p1 <= '0;
    end else if (state == ST_IDLE && start) begin
      csum_p1 <= '0;
    end else if (accept) begin
      csum_p1 <= csum_p1 + s_coef.s_coef_data;
    end
  end

  assign checksum = csum_p1;
`endif

endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
Writer-side companion to the FIR filter's coefficient-write port (coef_write_enable / coef_number / coef_value).
- Accepts a stream of N_TAPS coefficient bytes over a valid/ready handshake and sequences them into the filter as indexed single-cycle writes.
- Then flushes the filter delay line with zero samples and pulses done.
- Sits between the control/host path and the filter, gating the filter's input_data during reprogramming.

Parameters:
N_TAPS, 5, number of coefficients written per load (1..16)
COEF_W, 8, coefficient width
IDX_W, 4, coef_number width
DATA_W, 8, sample width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request a reload; sampled in IDLE only
abort  in  1  cancel an in-progress load/flush
s_coef_valid  in  1  coefficient byte available
s_coef_ready  out  1  loader accepts a coefficient byte
s_coef_data  in  COEF_W  coefficient byte, in tap order 0..N_TAPS-1
sample_in  in  DATA_W  upstream sample stream
sample_out  out  DATA_W  to filter input_data
coef_write_enable  out  1  to filter
coef_number  out  IDX_W  to filter
coef_value  out  COEF_W  to filter
busy  out  1  high in LOAD or FLUSH
done  out  1  one-cycle pulse on successful completion

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, idx=0, flush count=0.
  - All outputs 0: coef_write_enable, coef_number, coef_value, s_coef_ready, sample_out, busy, done.
- States and transitions:
  - IDLE -> LOAD on start=1.
  - LOAD -> FLUSH after the accept of tap N_TAPS-1.
  - FLUSH -> DONE after N_TAPS cycles.
  - DONE -> IDLE unconditionally after one cycle.
- IDLE:
  - s_coef_ready=0, busy=0.
  - sample_out <= sample_in (1-cycle registered passthrough).
  - start=1 -> LOAD, idx<=0; start and abort both high in IDLE -> start wins.
- LOAD:
  - s_coef_ready = (state==LOAD), combinational from state; busy=1.
  - sample_out <= 0 every cycle.
  - Accept = s_coef_valid & s_coef_ready. On accept, next cycle: coef_write_enable=1, coef_number=idx, coef_value=s_coef_data; idx increments.
  - Latency: 1 cycle from accept to write.
  - No accept -> coef_write_enable=0; coef_number/coef_value hold last values.
  - Accept with idx==N_TAPS-1 -> FLUSH; that final write still issues in the first FLUSH cycle.
  - Valid gaps of any length are legal; indices never skip or repeat.
- FLUSH:
  - s_coef_ready=0; sample_out=0 for exactly N_TAPS cycles, counted from FLUSH entry; busy=1.
  - Then DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - Passthrough resumes from the DONE cycle.
- start while busy: ignored, no queuing.
- abort in LOAD or FLUSH:
  - Next cycle IDLE; done is not pulsed.
  - A write registered from a same-cycle accept still issues; no further writes.
  - Filter holds a partial coefficient set; the host must reload.
  - abort in IDLE/DONE: ignored.
- Reset mid-operation: identical to abort plus all outputs cleared; any pending write is dropped.
- idx never exceeds N_TAPS-1. coef_number is zero-extended idx.

Optional Feature:
FIR_COEF_LOADER_CHECKSUM_EN
- Defined:
  - Adds output port checksum (COEF_W), the mod-2^COEF_W sum of all accepted coefficients of the current load.
  - Cleared to 0 on the start accept; updated on each accept; stable and valid when done=1; held until next start.
  - Reset value 0.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Shared package fir_pkg: COEF_W, DATA_W, IDX_W, default N_TAPS, and the state enum (IDLE, LOAD, FLUSH, DONE) as localparam encodings. The filter uses the same width constants.
- One sub-module: fir_tap_counter, a synchronous-clear, enable, terminal-count counter (IDX_W wide, terminal value N_TAPS-1). It is instantiated for the LOAD index and the FLUSH count.

Test Plan:
1. Reset, then start with bytes 3,7,1,9,2 (valid held high) -> writes (0,3),(1,7),(2,1),(3,9),(4,2) on 5 consecutive cycles, 1 cycle after each accept; sample_out=0 for 5 FLUSH cycles; done pulses once; busy low after.
2. Same load with valid low on alternate cycles -> identical write sequence, no duplicate or skipped coef_number, coef_write_enable low in gap cycles.
3. abort asserted after 2 accepts -> exactly 2 writes (0,1); IDLE next cycle; no done; a following start restarts at coef_number 0.
4. start pulsed during FLUSH, and rst_n=0 mid-LOAD -> start ignored (exactly one done); after reset all outputs 0, state IDLE, no write issued.
5. IDLE with sample_in = 5, then 9 -> sample_out = 5, then 9, one cycle later each; with start+abort together in IDLE, LOAD is entered.
6. (FIR_COEF_LOADER_CHECKSUM_EN) load 200,100,10,1,0 -> checksum=55 at done; reload with all zeros -> checksum=0.
